// File: rtl/mem_bus_arbiter_if.sv
// Bundles the requester ports (icache refill, MEM data) and the external
// memory bus used by mem_bus_arbiter.
//   master : arbiter view (drives bus_*, refill/data responses, stall_from_bus)
//   slave  : environment view (requesters plus memory slave)
interface mem_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // icache refill port
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic [DATA_W-1:0] ic_rdata;
   logic              ic_rvalid;
   logic              ic_done;
   // MEM-stage data port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_sel;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   // external memory bus
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [3:0]        bus_sel;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   // pipeline stall
   logic              stall_from_bus;

   modport master (
      input  ic_req, ic_addr, d_req, d_we, d_addr, d_wdata, d_sel, bus_ack, bus_rdata,
      output ic_rdata, ic_rvalid, ic_done, d_rdata, d_ack,
             bus_req, bus_we, bus_addr, bus_wdata, bus_sel, stall_from_bus
   );

   modport slave (
      output ic_req, ic_addr, d_req, d_we, d_addr, d_wdata, d_sel, bus_ack, bus_rdata,
      input  ic_rdata, ic_rvalid, ic_done, d_rdata, d_ack,
             bus_req, bus_we, bus_addr, bus_wdata, bus_sel, stall_from_bus
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one word-wide memory bus
// between the icache refill port (LINE_WORDS bursts) and the MEM data port.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_bus_arbiter_if.master: requester ports, memory bus, stall_from_bus
// bus_* outputs are registered; refill/data responses and stall_from_bus are
// combinational from state and bus_ack.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.master bus
);
   localparam int unsigned    CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int unsigned    OFF_W     = CNT_W + 2;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_GNT_I, S_GNT_D} state_t;
   typedef enum logic       {LG_I, LG_D}               gnt_t;

   state_t            r_state,     w_state_nxt;
   gnt_t              r_last_gnt,  w_last_gnt_nxt;
   logic [CNT_W-1:0]  r_word_cnt,  w_word_cnt_nxt;
   logic              r_bus_req,   w_bus_req_nxt;
   logic              r_bus_we,    w_bus_we_nxt;
   logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
   logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
   logic [3:0]        r_bus_sel,   w_bus_sel_nxt;

   logic w_pick_d;
   logic w_pick_i;
   logic w_ic_ack;
   logic w_d_ack;
   logic w_unused;

   // Line offset bits of the refill address are dropped (burst starts at base)
   assign w_unused = ^bus.ic_addr[OFF_W-1:0];

   // Round-robin: on contention the port that was not served last wins
   assign w_pick_d = bus.d_req & (~bus.ic_req | (r_last_gnt == LG_I));
   assign w_pick_i = bus.ic_req & ~w_pick_d;

   // State and bus registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last_gnt  <= LG_I;
         r_word_cnt  <= '0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_sel   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_last_gnt  <= w_last_gnt_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         r_bus_req   <= w_bus_req_nxt;
         r_bus_we    <= w_bus_we_nxt;
         r_bus_addr  <= w_bus_addr_nxt;
         r_bus_wdata <= w_bus_wdata_nxt;
         r_bus_sel   <= w_bus_sel_nxt;
      end
   end

   // Next-state and bus register update
   always_comb begin
      w_state_nxt     = r_state;
      w_last_gnt_nxt  = r_last_gnt;
      w_word_cnt_nxt  = r_word_cnt;
      w_bus_we_nxt    = r_bus_we;
      w_bus_addr_nxt  = r_bus_addr;
      w_bus_wdata_nxt = r_bus_wdata;
      w_bus_sel_nxt   = r_bus_sel;

      case (r_state)
         S_IDLE: begin
            if (w_pick_d) begin
               w_state_nxt     = S_GNT_D;
               w_bus_we_nxt    = bus.d_we;
               w_bus_addr_nxt  = bus.d_addr;
               w_bus_wdata_nxt = bus.d_wdata;
               w_bus_sel_nxt   = bus.d_sel;
            end else if (w_pick_i) begin
               w_state_nxt    = S_GNT_I;
               w_bus_we_nxt   = 1'b0;
               w_bus_addr_nxt = {bus.ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               w_bus_sel_nxt  = 4'b1111;
               w_word_cnt_nxt = '0;
            end
         end
         S_GNT_I: begin
            if (bus.bus_ack) begin
               w_word_cnt_nxt = CNT_W'(r_word_cnt + 1'b1);
               w_bus_addr_nxt = ADDR_W'(r_bus_addr + ADDR_W'(4));
               if (r_word_cnt == LAST_WORD) begin
                  w_state_nxt    = S_IDLE;
                  w_last_gnt_nxt = LG_I;
               end
            end
         end
         S_GNT_D: begin
            if (bus.bus_ack) begin
               w_state_nxt    = S_IDLE;
               w_last_gnt_nxt = LG_D;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Every transaction returns through IDLE, so bus_req drops for a cycle
      w_bus_req_nxt = (w_state_nxt != S_IDLE);
   end

   // bus_ack only counts for the port that currently owns the bus
   assign w_ic_ack = (r_state == S_GNT_I) & bus.bus_ack;
   assign w_d_ack  = (r_state == S_GNT_D) & bus.bus_ack;

   assign bus.ic_rvalid      = w_ic_ack;
   assign bus.ic_done        = w_ic_ack & (r_word_cnt == LAST_WORD);
   assign bus.ic_rdata       = w_ic_ack ? bus.bus_rdata : '0;
   assign bus.d_ack          = w_d_ack;
   assign bus.d_rdata        = w_d_ack ? bus.bus_rdata : '0;
   assign bus.stall_from_bus = bus.d_req & ~w_d_ack;

   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_bus_we;
   assign bus.bus_addr  = r_bus_addr;
   assign bus.bus_wdata = r_bus_wdata;
   assign bus.bus_sel   = r_bus_sel;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later, well before the next edge.
module tb_mem_bus_arbiter;
   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;

      // 1. Reset with both requests asserted and a stray bus_ack
      rst           = 1'b1;
      bif.ic_req    = 1'b1;
      bif.ic_addr   = 32'h0000_010C;
      bif.d_req     = 1'b1;
      bif.d_we      = 1'b0;
      bif.d_addr    = 32'h0000_2000;
      bif.d_wdata   = 32'h0;
      bif.d_sel     = 4'hF;
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_bus_req",   32'(bif.bus_req),   32'd0);
         chk("rst_ic_rvalid", 32'(bif.ic_rvalid), 32'd0);
         chk("rst_d_ack",     32'(bif.d_ack),     32'd0);
      end
      rst         = 1'b0;
      bif.bus_ack = 1'b0;

      // 2. First contention goes to D; load acked 2 cycles after bus_req rises
      tick();
      chk("t2_bus_req",  32'(bif.bus_req),        32'd1);
      chk("t2_addr",     bif.bus_addr,            32'h0000_2000);
      chk("t2_we",       32'(bif.bus_we),         32'd0);
      chk("t2_stall0",   32'(bif.stall_from_bus), 32'd1);
      chk("t2_noack0",   32'(bif.d_ack),          32'd0);
      tick();
      chk("t2_stall1",   32'(bif.stall_from_bus), 32'd1);
      chk("t2_noack1",   32'(bif.d_ack),          32'd0);
      tick();
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'hDEAD_BEEF;
      settle();
      chk("t2_d_ack",    32'(bif.d_ack),          32'd1);
      chk("t2_d_rdata",  bif.d_rdata,             32'hDEAD_BEEF);
      chk("t2_stall_ack",32'(bif.stall_from_bus), 32'd0);
      chk("t2_no_icv",   32'(bif.ic_rvalid),      32'd0);
      tick();
      bif.bus_ack = 1'b0;
      bif.d_req   = 1'b0;
      settle();
      chk("t2_idle",     32'(bif.bus_req),        32'd0);
      chk("t2_ack_low",  32'(bif.d_ack),          32'd0);

      // 3. Refill of line 0x10C, slave acks every cycle
      for (int k = 0; k < 4; k++) begin
         tick();
         bif.bus_ack   = 1'b1;
         bif.bus_rdata = 32'hA0 + 32'(k);
         settle();
         chk("t3_bus_req", 32'(bif.bus_req),   32'd1);
         chk("t3_addr",    bif.bus_addr,       32'h100 + 32'(4 * k));
         chk("t3_we",      32'(bif.bus_we),    32'd0);
         chk("t3_sel",     32'(bif.bus_sel),   32'hF);
         chk("t3_rvalid",  32'(bif.ic_rvalid), 32'd1);
         chk("t3_rdata",   bif.ic_rdata,       32'hA0 + 32'(k));
         chk("t3_done",    32'(bif.ic_done),   (k == 3) ? 32'd1 : 32'd0);
      end
      tick();
      bif.ic_req  = 1'b0;
      bif.bus_ack = 1'b0;
      settle();
      chk("t3_idle",     32'(bif.bus_req),   32'd0);
      chk("t3_rv_low",   32'(bif.ic_rvalid), 32'd0);

      // 4. Continuous contention, slave always acking: D, I, D, I
      bif.ic_addr = 32'h0000_0200;
      bif.d_addr  = 32'h0000_3000;
      bif.ic_req  = 1'b1;
      bif.d_req   = 1'b1;
      bif.bus_ack = 1'b1;
      bif.bus_rdata = 32'h5555_0000;
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("t4_d_req",   32'(bif.bus_req),   32'd1);
         chk("t4_d_addr",  bif.bus_addr,       32'h3000);
         chk("t4_d_ack",   32'(bif.d_ack),     32'd1);
         tick();
         chk("t4_gap_d",   32'(bif.bus_req),   32'd0);
         chk("t4_stall_gap", 32'(bif.stall_from_bus), 32'd1);
         for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_i_addr", bif.bus_addr,       32'h200 + 32'(4 * k));
            chk("t4_i_rv",   32'(bif.ic_rvalid), 32'd1);
            chk("t4_i_done", 32'(bif.ic_done),   (k == 3) ? 32'd1 : 32'd0);
            chk("t4_i_dack", 32'(bif.d_ack),     32'd0);
         end
         tick();
         chk("t4_gap_i",   32'(bif.bus_req),   32'd0);
      end
      bif.ic_req  = 1'b0;
      bif.d_req   = 1'b0;
      bif.bus_ack = 1'b0;

      // 5. Store raised during a refill waits for the burst to finish
      bif.ic_req  = 1'b1;
      bif.ic_addr = 32'h0000_0400;
      for (int k = 0; k < 4; k++) begin
         tick();
         bif.bus_ack = 1'b1;
         if (k == 1) begin
            bif.d_req   = 1'b1;
            bif.d_we    = 1'b1;
            bif.d_addr  = 32'h0000_5000;
            bif.d_wdata = 32'h0000_1234;
            bif.d_sel   = 4'b0011;
         end
         settle();
         chk("t5_addr",    bif.bus_addr,     32'h400 + 32'(4 * k));
         chk("t5_rvalid",  32'(bif.ic_rvalid), 32'd1);
         chk("t5_done",    32'(bif.ic_done), (k == 3) ? 32'd1 : 32'd0);
         chk("t5_no_dack", 32'(bif.d_ack),   32'd0);
         if (k >= 1) chk("t5_stall", 32'(bif.stall_from_bus), 32'd1);
      end
      tick();
      bif.ic_req  = 1'b0;
      bif.bus_ack = 1'b0;
      settle();
      chk("t5_idle",     32'(bif.bus_req),        32'd0);
      chk("t5_stall_idle", 32'(bif.stall_from_bus), 32'd1);
      tick();
      chk("t5_st_req",   32'(bif.bus_req),        32'd1);
      chk("t5_st_we",    32'(bif.bus_we),         32'd1);
      chk("t5_st_sel",   32'(bif.bus_sel),        32'h3);
      chk("t5_st_wdata", bif.bus_wdata,           32'h1234);
      chk("t5_st_addr",  bif.bus_addr,            32'h5000);
      chk("t5_st_wait",  32'(bif.stall_from_bus), 32'd1);
      bif.bus_ack = 1'b1;
      settle();
      chk("t5_st_ack",   32'(bif.d_ack),          32'd1);
      chk("t5_st_stall", 32'(bif.stall_from_bus), 32'd0);
      tick();
      bif.d_req   = 1'b0;
      bif.d_we    = 1'b0;
      bif.bus_ack = 1'b0;
      settle();
      chk("t5_end_idle", 32'(bif.bus_req),        32'd0);

      // 6. Reset after two acked refill words, then a fresh refill
      bif.ic_req  = 1'b1;
      bif.ic_addr = 32'h0000_0604;
      bif.bus_ack = 1'b1;
      tick();
      chk("t6_w0_addr",  bif.bus_addr, 32'h600);
      tick();
      chk("t6_w1_addr",  bif.bus_addr, 32'h604);
      tick();
      rst         = 1'b1;
      bif.bus_ack = 1'b0;
      settle();
      chk("t6_w2_addr",  bif.bus_addr, 32'h608);
      tick();
      chk("t6_rst_req",  32'(bif.bus_req),   32'd0);
      chk("t6_rst_addr", bif.bus_addr,       32'h0);
      rst = 1'b0;
      tick();
      bif.bus_ack = 1'b1;
      settle();
      chk("t6_re_req",   32'(bif.bus_req),   32'd1);
      chk("t6_re_addr",  bif.bus_addr,       32'h600);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         chk("t6_re_waddr", bif.bus_addr,     32'h600 + 32'(4 * k));
         chk("t6_re_done",  32'(bif.ic_done), (k == 3) ? 32'd1 : 32'd0);
      end
      tick();
      bif.ic_req  = 1'b0;
      bif.bus_ack = 1'b0;
      settle();
      chk("t6_end_idle", 32'(bif.bus_req),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
